// File: rtl/irq_claim_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ariane_soc: SoC-level interrupt constants shared by the interrupt scheduler
// and its testbench.
//
// Contents:
//   NumCVA6      number of CVA6 cores in the SoC
//   NumSources   interrupt sources; source ID k+1 is line k, ID 0 means none
//   NumTargets   hart contexts, one M-mode and one S-mode per core
//   MaxPriority  highest configurable priority
//   PrioW, IdW   priority and source-ID widths derived from the above
//   ScanWidth    sources examined per cycle by the scan engine
//   ceil_div()   integer ceiling division for chunk-count derivation
// ---------------------------------------------------------------------------
package ariane_soc;

    localparam int NumCVA6     = 2;
    localparam int NumSources  = 255;
    localparam int NumTargets  = 2 * NumCVA6;
    localparam int MaxPriority = 7;
    localparam int PrioW       = $clog2(MaxPriority + 1);
    localparam int IdW         = $clog2(NumSources + 1);
    localparam int ScanWidth   = 16;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/irq_claim_scheduler_gateway.sv
// ---------------------------------------------------------------------------
// irq_gateway: per-source interrupt gateway holding pending / in-flight state.
//
// Optional build macro: IRQ_EDGE_EN adds an edge_i input; when edge_i is 1
// the source pends on a rising edge of src_i (against a registered copy), and
// an edge that arrives while pending or in flight is remembered in a one-deep
// deferred flag that becomes pending when the in-flight state clears.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   src_i       interrupt line, already synchronised
//   edge_i      (IRQ_EDGE_EN only) 1 = edge-triggered source
//   claim_i     this source was granted to a hart this cycle
//   complete_i  a hart signalled completion of this source this cycle
//   pending_o   source is waiting to be claimed
// ---------------------------------------------------------------------------
module irq_gateway (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
`ifdef IRQ_EDGE_EN
    input  logic edge_i,
`endif
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);

    logic pending_q;
    logic inflight_q;
    logic set_req;

`ifdef IRQ_EDGE_EN
    logic src_q;
    logic deferred_q;
    logic rise;

    assign rise    = src_i & ~src_q;
    assign set_req = edge_i ? rise : src_i;
`else
    assign set_req = src_i;
`endif

    // Pending and in-flight are mutually exclusive: pending only sets while
    // not in flight, and a claim moves the source from one to the other.
    // Completion leaves pending clear, so a still-high level re-pends one
    // cycle later rather than in the completion cycle itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            pending_q  <= 1'b0;
            inflight_q <= 1'b0;
`ifdef IRQ_EDGE_EN
            src_q      <= 1'b0;
            deferred_q <= 1'b0;
`endif
        end else begin
`ifdef IRQ_EDGE_EN
            src_q <= src_i;
`endif
            if (claim_i && pending_q) begin
                pending_q  <= 1'b0;
                inflight_q <= 1'b1;
            end else if (complete_i && inflight_q) begin
                inflight_q <= 1'b0;
`ifdef IRQ_EDGE_EN
                pending_q  <= deferred_q | (edge_i & rise);
                deferred_q <= 1'b0;
`endif
            end else if (set_req && !pending_q && !inflight_q) begin
                pending_q <= 1'b1;
            end
`ifdef IRQ_EDGE_EN
            if (edge_i && rise && (pending_q || inflight_q) &&
                !(complete_i && inflight_q)) begin
                deferred_q <= 1'b1;
            end
`endif
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/irq_claim_scheduler.sv
// ---------------------------------------------------------------------------
// irq_claim_scheduler: interrupt scheduler between SoC interrupt sources and
// hart contexts. Per-source gateways track pending/in-flight; a time-
// multiplexed scan engine walks the sources ScanWidth at a time and, per
// target, keeps the highest-priority enabled pending source above that
// target's threshold. After each full sweep the winner is latched as best_id
// and drives irq_o. Harts claim and complete through pulse handshakes.
//
// Optional build macro: IRQ_EDGE_EN adds edge_i (per-source edge-trigger
// select), forwarded to the gateways.
//
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   src_i             level interrupt lines, already synchronised
//   edge_i            (IRQ_EDGE_EN only) per-source edge-trigger select
//   prio_i            per-source priority, PrioW bits each
//   ie_i              per-target enable, NumSources bits per target
//   threshold_i       per-target threshold, PrioW bits each
//   irq_o             interrupt request per target (registered)
//   claim_req_i       per-target claim pulse
//   claim_valid_o     claim response valid, one cycle after claim_req_i
//   claim_id_o        claimed ID per target (0 = nothing claimed)
//   complete_valid_i  per-target completion pulse
//   complete_id_i     completed ID per target
// ---------------------------------------------------------------------------
module irq_claim_scheduler #(
    parameter int  NumSources  = ariane_soc::NumSources,
    parameter int  NumTargets  = ariane_soc::NumTargets,
    parameter int  MaxPriority = ariane_soc::MaxPriority,
    parameter int  ScanWidth   = ariane_soc::ScanWidth,
    localparam int PrioW       = $clog2(MaxPriority + 1),
    localparam int IdW         = $clog2(NumSources + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumSources-1:0]            src_i,
`ifdef IRQ_EDGE_EN
    input  logic [NumSources-1:0]            edge_i,
`endif
    input  logic [NumSources*PrioW-1:0]      prio_i,
    input  logic [NumTargets*NumSources-1:0] ie_i,
    input  logic [NumTargets*PrioW-1:0]      threshold_i,
    output logic [NumTargets-1:0]            irq_o,
    input  logic [NumTargets-1:0]            claim_req_i,
    output logic [NumTargets-1:0]            claim_valid_o,
    output logic [NumTargets*IdW-1:0]        claim_id_o,
    input  logic [NumTargets-1:0]            complete_valid_i,
    input  logic [NumTargets*IdW-1:0]        complete_id_i
);

    localparam int NumChunks = ariane_soc::ceil_div(NumSources, ScanWidth);
    localparam int TotLanes  = NumChunks * ScanWidth;
    localparam int LaneW     = (TotLanes > 1) ? $clog2(TotLanes) : 1;
    localparam int ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    // Per-source views padded to a whole number of chunks; padding lanes read
    // as not pending / not enabled / priority 0.
    logic [TotLanes-1:0]   pending_pad;
    logic [PrioW-1:0]      prio_arr [TotLanes];
    logic [TotLanes-1:0]   ie_pad   [NumTargets];

    logic [NumSources-1:0] claim_src;
    logic [NumSources-1:0] complete_src;

    logic [ChunkW-1:0]     chunk_q;
    logic                  done_q;      // previous cycle evaluated the last chunk
    logic [LaneW-1:0]      chunk_base;
    logic [LaneW-1:0]      lane;
    logic [PrioW-1:0]      thr;

    logic [IdW-1:0]        acc_id_q   [NumTargets];
    logic [IdW-1:0]        acc_id_d   [NumTargets];
    logic [PrioW-1:0]      acc_prio_q [NumTargets];
    logic [PrioW-1:0]      acc_prio_d [NumTargets];
    logic [IdW-1:0]        best_id_q  [NumTargets];
    logic [IdW-1:0]        best_id_d  [NumTargets];

    logic [NumTargets-1:0] grant;
    logic [IdW-1:0]        resp_id    [NumTargets];

    // ------------------------------------------------------------------
    // Gateways and padded source views
    // ------------------------------------------------------------------
    for (genvar k = 0; k < TotLanes; k++) begin : g_lane
        if (k < NumSources) begin : g_real
            assign prio_arr[k] = prio_i[k*PrioW +: PrioW];
            for (genvar t = 0; t < NumTargets; t++) begin : g_ie
                assign ie_pad[t][k] = ie_i[t*NumSources + k];
            end

            irq_gateway u_gw (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .src_i      (src_i[k]),
`ifdef IRQ_EDGE_EN
                .edge_i     (edge_i[k]),
`endif
                .claim_i    (claim_src[k]),
                .complete_i (complete_src[k]),
                .pending_o  (pending_pad[k])
            );
        end else begin : g_pad
            assign prio_arr[k]    = '0;
            assign pending_pad[k] = 1'b0;
            for (genvar t = 0; t < NumTargets; t++) begin : g_ie
                assign ie_pad[t][k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan engine: merge one chunk per cycle into each target's accumulator.
    // Lanes are visited in ascending ID order and only a strictly higher
    // priority replaces the running best, so ties resolve to the lower ID.
    // The cycle after the last chunk starts a fresh sweep from zero while
    // the finished accumulator is latched into best_id.
    // ------------------------------------------------------------------
    assign chunk_base = LaneW'(chunk_q) * LaneW'(ScanWidth);

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        lane = '0;
        thr  = '0;
        for (int t = 0; t < NumTargets; t++) begin
            acc_id_d[t]   = done_q ? '0 : acc_id_q[t];
            acc_prio_d[t] = done_q ? '0 : acc_prio_q[t];
            thr           = threshold_i[t*PrioW +: PrioW];
            for (int l = 0; l < ScanWidth; l++) begin
                lane = chunk_base + LaneW'(l);
                // Priority 0 can never pass prio > threshold, even at threshold 0.
                if (int'(lane) < NumSources && pending_pad[lane] &&
                    ie_pad[t][lane] && prio_arr[lane] > thr &&
                    prio_arr[lane] > acc_prio_d[t]) begin
                    acc_prio_d[t] = prio_arr[lane];
                    acc_id_d[t]   = IdW'(lane) + IdW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Claim arbitration: a claim succeeds only if the latched best is still
    // pending; when several targets claim the same ID, the lowest index wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant = '0;
        for (int t = 0; t < NumTargets; t++) begin
            resp_id[t] = '0;
            if (claim_req_i[t] && best_id_q[t] != '0 &&
                pending_pad[LaneW'(best_id_q[t] - IdW'(1))]) begin
                grant[t] = 1'b1;
                for (int u = 0; u < t; u++) begin
                    if (grant[u] && best_id_q[u] == best_id_q[t]) begin
                        grant[t] = 1'b0;
                    end
                end
            end
            if (grant[t]) begin
                resp_id[t] = best_id_q[t];
            end
        end
    end

    // Decode granted and completed IDs onto per-source strobes. Matching
    // against k+1 means ID 0 and IDs above NumSources never hit a source.
    always_comb begin
        claim_src    = '0;
        complete_src = '0;
        for (int k = 0; k < NumSources; k++) begin
            for (int t = 0; t < NumTargets; t++) begin
                if (grant[t] && resp_id[t] == IdW'(k + 1)) begin
                    claim_src[k] = 1'b1;
                end
                if (complete_valid_i[t] &&
                    complete_id_i[t*IdW +: IdW] == IdW'(k + 1)) begin
                    complete_src[k] = 1'b1;
                end
            end
        end
    end

    // Next latched best: the finished sweep when one just ended, with any ID
    // claimed this cycle removed from every target.
    always_comb begin
        for (int t = 0; t < NumTargets; t++) begin
            best_id_d[t] = done_q ? acc_id_q[t] : best_id_q[t];
            for (int u = 0; u < NumTargets; u++) begin
                if (grant[u] && resp_id[u] == best_id_d[t]) begin
                    best_id_d[t] = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chunk_q       <= '0;
            done_q        <= 1'b0;
            irq_o         <= '0;
            claim_valid_o <= '0;
            claim_id_o    <= '0;
            // NOTE: these per-target arrays are control state, not storage;
            // they must come out of reset cleared, so each entry is reset.
            for (int t = 0; t < NumTargets; t++) begin
                acc_id_q[t]   <= '0;
                acc_prio_q[t] <= '0;
                best_id_q[t]  <= '0;
            end
        end else begin
            claim_valid_o <= claim_req_i;
            for (int t = 0; t < NumTargets; t++) begin
                claim_id_o[t*IdW +: IdW] <= resp_id[t];
                best_id_q[t]             <= best_id_d[t];
                irq_o[t]                 <= (best_id_d[t] != '0);
            end
            if (|grant) begin
                // A claim changes the pending set, so restart the sweep.
                chunk_q <= '0;
                done_q  <= 1'b0;
                for (int t = 0; t < NumTargets; t++) begin
                    acc_id_q[t]   <= '0;
                    acc_prio_q[t] <= '0;
                end
            end else begin
                for (int t = 0; t < NumTargets; t++) begin
                    acc_id_q[t]   <= acc_id_d[t];
                    acc_prio_q[t] <= acc_prio_d[t];
                end
                done_q  <= (chunk_q == ChunkW'(NumChunks - 1));
                chunk_q <= (chunk_q == ChunkW'(NumChunks - 1)) ? '0
                                                               : chunk_q + ChunkW'(1);
            end
        end
    end

endmodule

// File: tb/tb_irq_claim_scheduler.sv
// ---------------------------------------------------------------------------
// tb_irq_claim_scheduler: directed self-checking bench for
// irq_claim_scheduler at default parameters. Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_irq_claim_scheduler;
    import ariane_soc::*;

    localparam int NumChunks = ceil_div(NumSources, ScanWidth);
    localparam int Lat       = 2 * NumChunks + 1;

    logic                             clk_i = 1'b0;
    logic                             rst_i;
    logic [NumSources-1:0]            src_i;
`ifdef IRQ_EDGE_EN
    logic [NumSources-1:0]            edge_i;
`endif
    logic [NumSources*PrioW-1:0]      prio_i;
    logic [NumTargets*NumSources-1:0] ie_i;
    logic [NumTargets*PrioW-1:0]      threshold_i;
    logic [NumTargets-1:0]            irq_o;
    logic [NumTargets-1:0]            claim_req_i;
    logic [NumTargets-1:0]            claim_valid_o;
    logic [NumTargets*IdW-1:0]        claim_id_o;
    logic [NumTargets-1:0]            complete_valid_i;
    logic [NumTargets*IdW-1:0]        complete_id_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    irq_claim_scheduler dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .src_i            (src_i),
`ifdef IRQ_EDGE_EN
        .edge_i           (edge_i),
`endif
        .prio_i           (prio_i),
        .ie_i             (ie_i),
        .threshold_i      (threshold_i),
        .irq_o            (irq_o),
        .claim_req_i      (claim_req_i),
        .claim_valid_o    (claim_valid_o),
        .claim_id_o       (claim_id_o),
        .complete_valid_i (complete_valid_i),
        .complete_id_i    (complete_id_i)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_prio(input int id, input logic [PrioW-1:0] p);
        prio_i[(id-1)*PrioW +: PrioW] = p;
    endtask

    task automatic set_ie(input int t, input int id, input logic b);
        ie_i[t*NumSources + id - 1] = b;
    endtask

    task automatic set_thr(input int t, input logic [PrioW-1:0] p);
        threshold_i[t*PrioW +: PrioW] = p;
    endtask

    function automatic logic [IdW-1:0] cid(input int t);
        return claim_id_o[t*IdW +: IdW];
    endfunction

    // Pulse claim_req_i for one cycle; on return the response is visible.
    task automatic claim(input logic [NumTargets-1:0] mask);
        claim_req_i = mask;
        tick();
        claim_req_i = '0;
    endtask

    task automatic complete(input int t, input int id);
        complete_valid_i[t]          = 1'b1;
        complete_id_i[t*IdW +: IdW]  = IdW'(id);
        tick();
        complete_valid_i = '0;
        complete_id_i    = '0;
    endtask

    // Bounded wait for irq_o[t]; the caller checks irq_o afterwards, so an
    // expired bound shows up as a failed comparison.
    task automatic wait_irq(input int t, input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && irq_o[t] !== 1'b1) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        src_i            = '0;
`ifdef IRQ_EDGE_EN
        edge_i           = '0;
`endif
        prio_i           = '0;
        ie_i             = '0;
        threshold_i      = '0;
        claim_req_i      = '0;
        complete_valid_i = '0;
        complete_id_i    = '0;

        // ---- reset state ----
        ticks(3);
        check("rst_irq", irq_o, 0);
        check("rst_claim_valid", claim_valid_o, 0);
        check("rst_claim_id", claim_id_o, 0);
        rst_i = 1'b0;
        tick();

        // ---- claim with nothing pending returns ID 0 ----
        claim(4'b0100);
        check("empty_claim_valid", claim_valid_o, 4'b0100);
        check("empty_claim_id", cid(2), 0);
        tick();

        // ---- single source ID 5, prio 3, target 0 ----
        set_prio(5, 3);
        set_ie(0, 5, 1'b1);
        src_i[4] = 1'b1;
        wait_irq(0, Lat);
        check("t1_irq_raise", irq_o[0], 1);
        check("t1_irq_other_target", irq_o[1], 0);
        claim(4'b0001);
        check("t1_claim_valid", claim_valid_o, 4'b0001);
        check("t1_claim_id", cid(0), 5);
        tick();
        check("t1_claim_valid_drop", claim_valid_o, 0);
        check("t1_irq_drop", irq_o[0], 0);
        src_i[4] = 1'b0;
        complete(0, 5);

        // ---- ties go to lower ID; higher priority overrides ----
        set_prio(200, 3);
        set_ie(0, 200, 1'b1);
        src_i[4]   = 1'b1;
        src_i[199] = 1'b1;
        ticks(40);
        check("t2_irq", irq_o[0], 1);
        claim(4'b0001);
        check("t2_tie_id", cid(0), 5);
        // Complete 5 with its line still high so it re-pends, and raise 200.
        set_prio(200, 6);
        complete(0, 5);
        ticks(40);
        check("t2_irq_again", irq_o[0], 1);
        claim(4'b0001);
        check("t2_high_prio_id", cid(0), 200);
        tick();
        wait_irq(0, Lat);
        check("t2_irq_third", irq_o[0], 1);
        claim(4'b0001);
        check("t2_repend_id", cid(0), 5);
        src_i[4]   = 1'b0;
        src_i[199] = 1'b0;
        complete_valid_i             = 4'b0011;
        complete_id_i[0*IdW +: IdW]  = IdW'(200);
        complete_id_i[1*IdW +: IdW]  = IdW'(5);
        tick();
        complete_valid_i = '0;
        complete_id_i    = '0;
        set_prio(200, 0);

        // ---- threshold: prio must be strictly above ----
        set_prio(10, 3);
        set_ie(0, 10, 1'b1);
        set_thr(0, 3);
        src_i[9] = 1'b1;
        ticks(40);
        check("t3_thr_equal_blocks", irq_o[0], 0);
        set_thr(0, 2);
        wait_irq(0, Lat);
        check("t3_thr_below_raises", irq_o[0], 1);
        claim(4'b0001);
        check("t3_claim_id", cid(0), 10);
        src_i[9] = 1'b0;
        complete(0, 10);
        set_thr(0, 0);

        // ---- simultaneous claims: same ID and distinct IDs ----
        set_prio(7, 2);
        set_ie(0, 7, 1'b1);
        set_ie(1, 7, 1'b1);
        set_prio(20, 1);
        set_ie(2, 20, 1'b1);
        set_prio(30, 1);
        set_ie(3, 30, 1'b1);
        src_i[6]  = 1'b1;
        src_i[19] = 1'b1;
        src_i[29] = 1'b1;
        ticks(40);
        check("t4_irq_all", irq_o, 4'b1111);
        claim(4'b1111);
        check("t4_claim_valid", claim_valid_o, 4'b1111);
        check("t4_t0_wins", cid(0), 7);
        check("t4_t1_loses", cid(1), 0);
        check("t4_t2_id", cid(2), 20);
        check("t4_t3_id", cid(3), 30);
        tick();
        check("t4_irq_drop", irq_o, 0);
        src_i[6]  = 1'b0;
        src_i[19] = 1'b0;
        src_i[29] = 1'b0;
        complete_valid_i             = 4'b0111;
        complete_id_i[0*IdW +: IdW]  = IdW'(7);
        complete_id_i[1*IdW +: IdW]  = IdW'(20);
        complete_id_i[2*IdW +: IdW]  = IdW'(30);
        tick();
        complete_valid_i = '0;
        complete_id_i    = '0;

        // ---- held level: no re-pend while in flight; bogus completes ----
        set_prio(9, 4);
        set_ie(0, 9, 1'b1);
        src_i[8] = 1'b1;
        wait_irq(0, Lat);
        check("t5_irq", irq_o[0], 1);
        claim(4'b0001);
        check("t5_claim_id", cid(0), 9);
        ticks(40);
        check("t5_no_repend_inflight", irq_o[0], 0);
        complete_valid_i             = 4'b0011;
        complete_id_i[0*IdW +: IdW]  = IdW'(0);
        complete_id_i[1*IdW +: IdW]  = IdW'(12);
        tick();
        complete_valid_i = '0;
        complete_id_i    = '0;
        ticks(40);
        check("t5_bogus_complete_ignored", irq_o[0], 0);
        complete(0, 9);
        wait_irq(0, Lat + 1);
        check("t5_repend_after_complete", irq_o[0], 1);
        claim(4'b0001);
        check("t5_reclaim_id", cid(0), 9);
        src_i[8] = 1'b0;
        complete(0, 9);

        // ---- reset mid-sweep with irq high and a claim in flight ----
        set_prio(3, 1);
        set_ie(0, 3, 1'b1);
        src_i[2] = 1'b1;
        wait_irq(0, Lat);
        check("t6_irq_before_rst", irq_o[0], 1);
        rst_i       = 1'b1;
        claim_req_i = 4'b0001;
        tick();
        check("t6_rst_irq", irq_o, 0);
        check("t6_rst_claim_valid", claim_valid_o, 0);
        check("t6_rst_claim_id", claim_id_o, 0);
        rst_i       = 1'b0;
        claim_req_i = '0;
        // ID 3 pends on the first edge after release, which is also the edge
        // that consumes chunk 0, so it first appears after two full sweeps.
        ticks(Lat - 1);
        check("t6_irq_not_yet", irq_o[0], 0);
        tick();
        check("t6_irq_restart_latency", irq_o[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
